// File: rtl/nios2arm_fifo.sv
// nios2arm_fifo: show-ahead message FIFO carrying 32-bit words from the NIOS
// subsystem to the HPS PIOs. Pop and flush requests arrive as software-toggled
// PIO levels and are acted on at their rising edges only.
module nios2arm_fifo #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int OVF_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     nios_wr_data,
  input  logic                  nios_wr_en,
  output logic                  nios_full,
  output logic [DEPTH_LOG2:0]   nios_level,
  input  logic                  read_fifo,
  input  logic                  clearfifo,
  output logic [DATA_W-1:0]     fifo_data,
  output logic                  not_empty,
  output logic [OVF_W-1:0]      overflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [OVF_W-1:0] OVF_MAX       = {OVF_W{1'b1}};
  localparam logic [OVF_W-1:0] OVF_ONE       = {{(OVF_W-1){1'b0}}, 1'b1};

  // Storage is deliberately left unreset; count_r alone decides validity.
  logic [DATA_W-1:0]     mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [OVF_W-1:0]      ovf_cnt_r;
  logic                  read_prev_r;
  logic                  clear_prev_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  pop_req_s;
  logic                  clr_req_s;
  logic                  push_s;
  logic                  drop_s;

  // Request decode: edge detection plus push/drop qualification.
  always_comb begin
    full_s    = (count_r == COUNT_FULL);
    empty_s   = (count_r == {(DEPTH_LOG2+1){1'b0}});
    pop_req_s = read_fifo & ~read_prev_r & ~empty_s;
    clr_req_s = clearfifo & ~clear_prev_r;
    push_s    = nios_wr_en & (~full_s | pop_req_s);
    drop_s    = nios_wr_en & full_s & ~pop_req_s;
  end

  // Control state: pointers, occupancy, overflow counter and edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r     <= {DEPTH_LOG2{1'b0}};
      count_r      <= {(DEPTH_LOG2+1){1'b0}};
      ovf_cnt_r    <= {OVF_W{1'b0}};
      // Start "high" so a level already asserted at release is not an edge.
      read_prev_r  <= 1'b1;
      clear_prev_r <= 1'b1;
    end else begin
      read_prev_r  <= read_fifo;
      clear_prev_r <= clearfifo;
      if (clr_req_s) begin
        // Flush wins over any coincident push or pop.
        wr_ptr_r  <= {DEPTH_LOG2{1'b0}};
        rd_ptr_r  <= {DEPTH_LOG2{1'b0}};
        count_r   <= {(DEPTH_LOG2+1){1'b0}};
        ovf_cnt_r <= {OVF_W{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_req_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
        case ({push_s, pop_req_s})
          2'b10:   count_r <= count_r + COUNT_ONE;
          2'b01:   count_r <= count_r - COUNT_ONE;
          default: count_r <= count_r;
        endcase
        if (drop_s && (ovf_cnt_r != OVF_MAX)) begin
          ovf_cnt_r <= ovf_cnt_r + OVF_ONE;
        end else begin
          ovf_cnt_r <= ovf_cnt_r;
        end
      end
    end
  end

  // Storage write port; a write coinciding with a flush or reset is discarded.
  always_ff @(posedge clk) begin
    if (push_s && !clr_req_s && !reset) begin
      mem_r[wr_ptr_r] <= nios_wr_data;
    end
  end

  // Outputs are decoded purely from registered state.
  always_comb begin
    nios_full    = full_s;
    nios_level   = count_r;
    not_empty    = ~empty_s;
    overflow_cnt = ovf_cnt_r;
    if (!empty_s) begin
      fifo_data = mem_r[rd_ptr_r];
    end else begin
      fifo_data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_nios2arm_fifo.sv
// Testbench for nios2arm_fifo: directed scenarios followed by constrained
// and fully random traffic, checked every cycle against a queue-based model.
module tb_nios2arm_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nios_wr_data;
  logic        nios_wr_en;
  logic        nios_full;
  logic [4:0]  nios_level;
  logic        read_fifo;
  logic        clearfifo;
  logic [31:0] fifo_data;
  logic        not_empty;
  logic [7:0]  overflow_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int unsigned q[$];
  bit          rd_prev_m;
  bit          clr_prev_m;
  int          ovf_m;

  nios2arm_fifo #(.DATA_W(32), .DEPTH_LOG2(4), .OVF_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .nios_wr_data (nios_wr_data),
    .nios_wr_en   (nios_wr_en),
    .nios_full    (nios_full),
    .nios_level   (nios_level),
    .read_fifo    (read_fifo),
    .clearfifo    (clearfifo),
    .fifo_data    (fifo_data),
    .not_empty    (not_empty),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the behavioural model, using the inputs seen at that edge.
  task automatic model_step(input bit rst, input bit we, input int unsigned d, input bit rd, input bit cl);
    bit pop, clr, full;
    if (rst) begin
      q.delete();
      rd_prev_m  = 1'b1;
      clr_prev_m = 1'b1;
      ovf_m      = 0;
    end else begin
      pop  = rd && !rd_prev_m && (q.size() != 0);
      clr  = cl && !clr_prev_m;
      full = (q.size() == 16);
      if (clr) begin
        q.delete();
        ovf_m = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (we) begin
          if (!full || pop) q.push_back(d);
          else if (ovf_m < 255) ovf_m++;
        end
      end
      rd_prev_m  = rd;
      clr_prev_m = cl;
    end
  endtask

  task automatic check_all();
    int unsigned head;
    head = (q.size() != 0) ? q[0] : 32'd0;
    chk("fifo_data", fifo_data, head);
    chk("not_empty", {31'd0, not_empty}, (q.size() != 0) ? 32'd1 : 32'd0);
    chk("nios_level", {27'd0, nios_level}, q.size());
    chk("nios_full", {31'd0, nios_full}, (q.size() == 16) ? 32'd1 : 32'd0);
    chk("overflow_cnt", {24'd0, overflow_cnt}, ovf_m);
  endtask

  task automatic cycle(input bit rst, input bit we, input logic [31:0] d, input bit rd, input bit cl);
    reset        = rst;
    nios_wr_en   = we;
    nios_wr_data = d;
    read_fifo    = rd;
    clearfifo    = cl;
    @(posedge clk);
    model_step(rst, we, d, rd, cl);
    #1;
    check_all();
  endtask

  task automatic pop_toggle();
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int lvl;
    bit do_wr, do_rd;
    bit r_rst, r_we, r_rd, r_cl;

    // Reset with PIO levels already high; no spurious pop/flush after release.
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("idle_not_empty", {31'd0, not_empty}, 32'd0);
    chk("idle_fifo_data", fifo_data, 32'd0);
    chk("idle_level", {27'd0, nios_level}, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Three writes, three pops with show-ahead data.
    cycle(1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
    chk("first_word_latency", fifo_data, 32'h11);
    cycle(1'b0, 1'b1, 32'h22, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h33, 1'b0, 1'b0);
    pop_toggle();
    chk("after_pop1", fifo_data, 32'h22);
    pop_toggle();
    chk("after_pop2", fifo_data, 32'h33);
    pop_toggle();
    chk("after_pop3_empty", {31'd0, not_empty}, 32'd0);

    // Fill, overflow by three, drain in order.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 32'h100 + i, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("full_flag", {31'd0, nios_full}, 32'd1);
    chk("ovf_three", {24'd0, overflow_cnt}, 32'd3);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", fifo_data, 32'h100 + i);
      pop_toggle();
    end

    // Full with coincident pop and write: write accepted, level stays 16.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 32'h200 + i, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'hBEEF, 1'b1, 1'b0);
    chk("full_pop_level", {27'd0, nios_level}, 32'd16);
    chk("full_pop_ovf", {24'd0, overflow_cnt}, 32'd3);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) pop_toggle();
    chk("beef_last", fifo_data, 32'hBEEF);
    pop_toggle();

    // Held-high read pops only once.
    cycle(1'b0, 1'b1, 32'h51, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h52, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("held_read_once", fifo_data, 32'h52);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    pop_toggle();

    // Empty-and-push: the read edge is discarded.
    cycle(1'b0, 1'b1, 32'h61, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("empty_push_edge_lost", {27'd0, nios_level}, 32'd1);
    pop_toggle();

    // Saturating overflow, then flush with a coincident write.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 32'h300 + i, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    chk("ovf_saturate", {24'd0, overflow_cnt}, 32'd255);
    cycle(1'b0, 1'b1, 32'hCAFE, 1'b0, 1'b1);
    chk("flush_level", {27'd0, nios_level}, 32'd0);
    chk("flush_ovf", {24'd0, overflow_cnt}, 32'd0);
    chk("flush_not_empty", {31'd0, not_empty}, 32'd0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Pointer wrap with occupancy kept around 1..3.
    for (int i = 0; i < 60; i++) begin
      lvl   = q.size();
      do_wr = (lvl < 2) ? 1'b1 : ((lvl >= 3) ? 1'b0 : 1'($urandom % 2));
      do_rd = (lvl >= 3) ? 1'b1 : ((lvl >= 2) ? 1'($urandom % 2) : 1'b0);
      cycle(1'b0, do_wr, $urandom, do_rd, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    end

    // Fully random traffic including rare flushes and resets.
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom % 100) == 0;
      r_we  = ($urandom % 3) != 0;
      r_rd  = ($urandom % 2) == 0;
      r_cl  = ($urandom % 40) == 0;
      cycle(r_rst, r_we, $urandom, r_rd, r_cl);
    end

    // Mid-operation reset discards contents.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h700 + i, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h7FF, 1'b0, 1'b0);
    chk("midreset_level", {27'd0, nios_level}, 32'd0);
    chk("midreset_data", fifo_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
